// File: rtl/team_06_playback_fifo.sv
// Speaker-path jitter buffer: circular sample store that holds output at silence
// until a prefill level is reached, then plays out one sample per read request.
module team_06_playback_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PREFILL = 8,
  parameter logic [7:0]  SILENCE = 8'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  input  logic                     rd_req,
  input  logic                     flush,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     playing,
  output logic                     underrun,
  output logic                     overflow,
  output logic [7:0]               underrun_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic {
    FILL = 1'b0,
    PLAY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            underrun_q, underrun_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      ucnt_q, ucnt_d;
  logic [7:0]      mem_q [DEPTH];

  logic            pop;
  logic            push;
  logic            starve;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    underrun_d = 1'b0;
    overflow_d = overflow_q;
    ucnt_d     = ucnt_q;
    pop        = 1'b0;
    push       = 1'b0;
    starve     = 1'b0;

    if (flush) begin
      state_d    = FILL;
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      ucnt_d     = '0;
      rd_data_d  = SILENCE;
    end else begin
      if (rd_req) begin
        rd_valid_d = 1'b1;
        rd_data_d  = SILENCE;
        if (state_q == PLAY) begin
          if (level_q != '0) begin
            pop       = 1'b1;
            rd_data_d = mem_q[rptr_q];
          end else begin
            starve = 1'b1;
          end
        end
      end

      // A same-cycle pop frees a slot, so a write at full is still accepted.
      if (wr_valid) begin
        if ((level_q != LW'(DEPTH)) || pop) begin
          push = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end

      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);

      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase

      if (starve) begin
        underrun_d = 1'b1;
        if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
      end

      case (state_q)
        FILL:    if (level_q >= LW'(PREFILL)) state_d = PLAY;
        PLAY:    if (starve) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      rd_data_q  <= SILENCE;
      rd_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      ucnt_q     <= ucnt_d;
    end
  end

  // Sample storage needs no reset; level and pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign level          = level_q;
  assign playing        = (state_q == PLAY);
  assign underrun       = underrun_q;
  assign overflow       = overflow_q;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_team_06_playback_fifo.sv
// Directed bench for team_06_playback_fifo: queue-based reference model with a
// scoreboard of expected read samples checked whenever rd_valid fires.
module tb_team_06_playback_fifo;

  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_req;
  logic       flush;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] level;
  logic       playing;
  logic       underrun;
  logic       overflow;
  logic [7:0] underrun_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_q [$];
  logic [7:0] sb [$];
  bit         m_play;
  bit         m_ovf;
  int         m_ucnt;

  team_06_playback_fifo #(
    .DEPTH   (DEPTH),
    .PREFILL (PREFILL),
    .SILENCE (8'd0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .rd_req         (rd_req),
    .flush          (flush),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .level          (level),
    .playing        (playing),
    .underrun       (underrun),
    .overflow       (overflow),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    m_play = 1'b0;
    m_ovf  = 1'b0;
    m_ucnt = 0;
  endtask

  // One clock cycle of stimulus; the model predicts the state after the edge.
  task automatic cyc(input bit wv, input logic [7:0] wd, input bit rr, input bit fl);
    bit pop, und, acc;
    int sz;
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    flush    = fl;
    sz  = m_q.size();
    pop = 1'b0;
    und = 1'b0;
    if (fl) begin
      m_q.delete();
      m_play = 1'b0;
      m_ovf  = 1'b0;
      m_ucnt = 0;
    end else begin
      pop = rr && m_play && (sz > 0);
      und = rr && m_play && (sz == 0);
      if (rr) sb.push_back(pop ? m_q[0] : 8'h00);
      acc = wv && ((sz < DEPTH) || pop);
      if (wv && !acc) m_ovf = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(wd);
      if (und) begin
        m_play = 1'b0;
        if (m_ucnt < 255) m_ucnt++;
      end else if (!m_play && sz >= PREFILL) begin
        m_play = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    flush    = 1'b0;
    chk("rd_valid", rd_valid, rr && !fl);
    chk("underrun", underrun, und);
    chk("level", level, m_q.size());
    chk("playing", playing, m_play);
    chk("overflow", overflow, m_ovf);
    chk("underrun_count", underrun_count, m_ucnt);
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1 && rst === 1'b0) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL sb_empty: observed rd_valid with data %0h expected no output", rd_data);
      end
      if (sb.size() > 0) chk("rd_data", rd_data, sb.pop_front());
    end
  end

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_req   = 1'b0;
    flush    = 1'b0;
    model_reset();
    #12;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_playing", playing, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ucnt", underrun_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reads while filling return silence with no underrun.
    repeat (3) cyc(0, 8'h00, 1, 0);

    for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
    chk("prefill_level", level, 8);
    chk("prefill_gap_playing", playing, 0);
    cyc(0, 8'h00, 0, 0);
    chk("play_rise", playing, 1);
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
    chk("drained_level", level, 0);

    cyc(0, 8'h00, 1, 0);
    chk("starve_underrun", underrun, 1);
    chk("starve_count", underrun_count, 1);
    chk("starve_playing", playing, 0);

    for (int i = 0; i < 17; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
    chk("full_level", level, 16);
    chk("full_overflow", overflow, 1);

    cyc(1, 8'hA5, 1, 0);
    chk("full_rw_level", level, 16);
    chk("full_rw_overflow", overflow, 1);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);

    for (int i = 0; i < 5; i++) cyc(1, 8'h50 + 8'(i), 0, 0);
    chk("pre_flush_level", level, 5);
    chk("pre_flush_playing", playing, 1);
    cyc(1, 8'h77, 1, 1);
    chk("flush_level", level, 0);
    chk("flush_playing", playing, 0);
    chk("flush_overflow", overflow, 0);
    chk("flush_ucnt", underrun_count, 0);
    chk("flush_rd_valid", rd_valid, 0);
    chk("flush_rd_data", rd_data, 0);

    repeat (300) begin
      for (int i = 0; i < 8; i++) cyc(1, 8'(i) + 8'h01, 0, 0);
      cyc(0, 8'h00, 0, 0);
      for (int i = 0; i < 9; i++) cyc(0, 8'h00, 1, 0);
    end
    chk("ucnt_saturate", underrun_count, 255);

    for (int i = 0; i < 8; i++) cyc(1, 8'h60 + 8'(i), 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h68, 0, 0);
    cyc(1, 8'h69, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd_data", rd_data, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_playing", playing, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_ucnt", underrun_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    repeat (2) cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 8'h80 + 8'(i), 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("post_rst_level", level, 7);

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
